// File: rtl/mem_sweep_pkg.sv
// Shared types and the signature fold for the memory sweep controller and its
// readback helpers.
package mem_sweep_pkg;

  localparam int SIG_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_SIG   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } sweep_state_e;

  typedef enum logic [1:0] {
    MODE_SIG  = 2'd0,
    MODE_FILL = 2'd1
  } sweep_mode_e;

  // Rotate left by one, then XOR in the (already zero-extended) data word.
  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                input logic [SIG_W-1:0] data);
    return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ data;
  endfunction

endpackage

// File: rtl/mem_sweep_sig.sv
// Signature accumulator: clear has priority, otherwise folds data when valid.
// sig_nxt exposes the value sig takes at the next edge.
module mem_sweep_sig
  import mem_sweep_pkg::*;
#(
  parameter int WID = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [WID-1:0]   data,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_nxt
);

  logic [SIG_W-1:0] data_ext;
  assign data_ext = SIG_W'(data);

  always_comb begin
    sig_nxt = sig;
    if (clear)      sig_nxt = '0;
    else if (valid) sig_nxt = sig_step(sig, data_ext);
  end

  always_ff @(posedge clk) begin
    if (!reset) sig <= '0;
    else        sig <= sig_nxt;
  end

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Sweep sequencer and user-port arbiter in front of one registered-read RAM.
// FILL writes a constant everywhere; SIG folds every word into a signature.
module mem_sweep_ctrl
  import mem_sweep_pkg::*;
#(
  parameter int WID_MEM   = 2,
  parameter int DEPTH_MEM = 8192
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WID_MEM-1:0] fill_val,
  input  logic [31:0]        sig_exp,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        sig,
  output logic               sig_ok,
  input  logic               user_req,
  input  logic               user_we,
  input  logic [31:0]        user_addr,
  input  logic [WID_MEM-1:0] user_din,
  output logic               user_gnt,
  output logic               user_rvalid,
  output logic [WID_MEM-1:0] user_dout,
  output logic [31:0]        mem_raddr,
  output logic [31:0]        mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  output logic               mem_we,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic [2:0]         dbg_state
);

  localparam int CNT_W = $clog2(DEPTH_MEM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH_MEM - 1);

  sweep_state_e       state;
  logic [CNT_W-1:0]   cnt;
  logic               vld_q;
  logic [WID_MEM-1:0] fill_val_q;
  logic [31:0]        sig_exp_q;
  logic [31:0]        sig_nxt;
  logic               sig_clear;

  assign dbg_state = state;
  assign sig_clear = (state == ST_IDLE) && start;

  mem_sweep_sig #(.WID(WID_MEM)) u_sig (
    .clk     (clk),
    .reset   (reset),
    .clear   (sig_clear),
    .valid   (vld_q),
    .data    (mem_dout),
    .sig     (sig),
    .sig_nxt (sig_nxt)
  );

  // User handshake: an access is taken in any cycle with user_req && user_gnt
  // and completes that cycle; a read returns user_dout with user_rvalid one
  // cycle later. The requester holds user_req (and its fields) until granted.
  assign user_gnt  = (state == ST_IDLE) && user_req;
  assign user_dout = mem_dout;

  always_comb begin
    mem_we    = 1'b0;
    mem_raddr = '0;
    mem_waddr = '0;
    mem_din   = '0;
    case (state)
      ST_IDLE: begin
        if (user_req) begin
          mem_we    = user_we;
          mem_raddr = user_addr;
          mem_waddr = user_addr;
          mem_din   = user_din;
        end
      end
      ST_FILL: begin
        mem_we    = 1'b1;
        mem_waddr = 32'(cnt);
        mem_din   = fill_val_q;
      end
      ST_SIG:  mem_raddr = 32'(cnt);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      vld_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      sig_ok      <= 1'b0;
      user_rvalid <= 1'b0;
      fill_val_q  <= '0;
      sig_exp_q   <= '0;
    end else begin
      done        <= 1'b0;
      user_rvalid <= 1'b0;
      // The read issued in a SIG cycle returns data one cycle later.
      vld_q       <= (state == ST_SIG);
      case (state)
        ST_IDLE: begin
          user_rvalid <= user_req && !user_we;
          if (start) begin
            fill_val_q <= fill_val;
            sig_exp_q  <= sig_exp;
            cnt        <= '0;
            busy       <= 1'b1;
            sig_ok     <= 1'b0;
            err        <= 1'b0;
            case (sweep_mode_e'(mode))
              MODE_SIG:  state <= ST_SIG;
              MODE_FILL: state <= ST_FILL;
              default: begin
                state <= ST_FIN;
                err   <= 1'b1;
                done  <= 1'b1;
              end
            endcase
          end
        end
        ST_FILL: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state  <= ST_FIN;
            done   <= 1'b1;
            sig_ok <= (sig_nxt == sig_exp_q);
          end
        end
        ST_SIG: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // sig_nxt already includes the last word folded at this edge.
          state  <= ST_FIN;
          done   <= 1'b1;
          sig_ok <= (sig_nxt == sig_exp_q);
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Directed bench for mem_sweep_ctrl with a 16x2 registered-read RAM model.
module tb_mem_sweep_ctrl;
  localparam int WID = 2;
  localparam int DEP = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [WID-1:0]  fill_val = '0;
  logic [31:0]     sig_exp = '0;
  logic            busy, done, err, sig_ok;
  logic [31:0]     sig;
  logic            user_req = 1'b0, user_we = 1'b0;
  logic [31:0]     user_addr = '0;
  logic [WID-1:0]  user_din = '0;
  logic            user_gnt, user_rvalid;
  logic [WID-1:0]  user_dout;
  logic [31:0]     mem_raddr, mem_waddr;
  logic [WID-1:0]  mem_din, mem_dout;
  logic            mem_we;
  logic [2:0]      dbg_state;

  logic [WID-1:0]  ram [DEP];
  logic [WID-1:0]  exp_mem [DEP];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr[3:0]] <= mem_din;
    mem_dout <= ram[mem_raddr[3:0]];
  end

  mem_sweep_ctrl #(.WID_MEM(WID), .DEPTH_MEM(DEP)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .fill_val(fill_val),
    .sig_exp(sig_exp), .busy(busy), .done(done), .err(err), .sig(sig),
    .sig_ok(sig_ok), .user_req(user_req), .user_we(user_we),
    .user_addr(user_addr), .user_din(user_din), .user_gnt(user_gnt),
    .user_rvalid(user_rvalid), .user_dout(user_dout), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle c0+1.
  task automatic start_sweep(input logic [1:0] m, input logic [WID-1:0] fv,
                             input logic [31:0] se);
    start = 1'b1; mode = m; fill_val = fv; sig_exp = se;
    tick;
    start = 1'b0;
  endtask

  // Called in cycle c0+1; lat returns n such that done was seen in c0+n.
  task automatic wait_done(input int max, output int lat);
    lat = 1;
    while (!done && lat < max) begin
      tick;
      lat++;
    end
  endtask

  task automatic user_wr(input logic [31:0] a, input logic [WID-1:0] d);
    user_req = 1'b1; user_we = 1'b1; user_addr = a; user_din = d;
    tick;
    user_req = 1'b0; user_we = 1'b0;
    exp_mem[a[3:0]] = d;
  endtask

  function automatic logic [31:0] model_sig();
    logic [31:0] s = '0;
    for (int i = 0; i < DEP; i++) s = {s[30:0], s[31]} ^ {30'b0, exp_mem[i]};
    return s;
  endfunction

  function automatic int ram_bad();
    int b = 0;
    for (int i = 0; i < DEP; i++) if (ram[i] !== exp_mem[i]) b++;
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    int cnt_a;
    logic [31:0] ref_sig;

    repeat (3) tick;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_sig", sig, 32'd0);
    chk("rst_sig_ok", {31'b0, sig_ok}, 32'd0);
    chk("rst_rvalid", {31'b0, user_rvalid}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    reset = 1'b1;
    tick;

    // FILL with 2'b10, then SIG; 16 words of 2 fold to 2^17-2 = 0x1FFFE.
    start_sweep(2'd1, 2'b10, 32'd0);
    wait_done(40, lat);
    chk("fill_lat", lat, DEP + 1);
    chk("fill_busy_at_done", {31'b0, busy}, 32'd1);
    chk("fill_err", {31'b0, err}, 32'd0);
    tick;
    chk("fill_done_pulse", {31'b0, done}, 32'd0);
    chk("fill_busy_after", {31'b0, busy}, 32'd0);
    for (int i = 0; i < DEP; i++) exp_mem[i] = 2'b10;
    chk("fill_contents", ram_bad(), 32'd0);

    start_sweep(2'd0, 2'b00, 32'h0001_FFFE);
    wait_done(40, lat);
    chk("sig_lat", lat, DEP + 2);
    chk("sig_const", sig, 32'h0001_FFFE);
    chk("sig_ok_const", {31'b0, sig_ok}, 32'd1);
    tick;
    chk("sig_hold", sig, 32'h0001_FFFE);
    chk("sig_ok_hold", {31'b0, sig_ok}, 32'd1);

    // Load an image through the user port, then SIG with a wrong and right expectation.
    user_req = 1'b1; user_we = 1'b1; user_addr = 32'd0; user_din = 2'd1;
    #1;
    chk("idle_gnt", {31'b0, user_gnt}, 32'd1);
    chk("idle_mem_we", {31'b0, mem_we}, 32'd1);
    tick;
    user_req = 1'b0; user_we = 1'b0;
    exp_mem[0] = 2'd1;
    for (int i = 1; i < DEP; i++) user_wr(i, WID'((5 * i + 1) % 4));
    chk("image_contents", ram_bad(), 32'd0);
    ref_sig = model_sig();

    start_sweep(2'd0, 2'b00, ref_sig ^ 32'h1);
    wait_done(40, lat);
    chk("img_sig", sig, ref_sig);
    chk("img_sig_ok_wrong", {31'b0, sig_ok}, 32'd0);
    tick;
    start_sweep(2'd0, 2'b00, ref_sig);
    wait_done(40, lat);
    chk("img_sig_ok_right", {31'b0, sig_ok}, 32'd1);
    tick;

    // User read of address 5 in the same cycle as start(SIG).
    user_req = 1'b1; user_we = 1'b0; user_addr = 32'd5;
    start = 1'b1; mode = 2'd0; sig_exp = ref_sig;
    #1;
    chk("same_cycle_gnt", {31'b0, user_gnt}, 32'd1);
    tick;
    start = 1'b0; user_req = 1'b0;
    chk("same_cycle_rvalid", {31'b0, user_rvalid}, 32'd1);
    chk("same_cycle_rdata", {30'b0, user_dout}, {30'b0, exp_mem[5]});
    wait_done(40, lat);
    chk("same_cycle_lat", lat, DEP + 2);
    chk("same_cycle_sig", sig, ref_sig);
    chk("same_cycle_sig_ok", {31'b0, sig_ok}, 32'd1);
    tick;

    // User write held through a FILL sweep stalls until IDLE.
    start_sweep(2'd1, 2'b11, 32'd0);
    user_req = 1'b1; user_we = 1'b1; user_addr = 32'd3; user_din = 2'd1;
    cnt_a = 0;
    lat = 1;
    while (!done && lat < 40) begin
      #1;
      if (user_gnt) cnt_a++;
      tick;
      lat++;
    end
    if (user_gnt) cnt_a++;
    chk("stall_lat", lat, DEP + 1);
    chk("stall_no_gnt", cnt_a, 32'd0);
    tick;
    chk("stall_gnt_idle", {31'b0, user_gnt}, 32'd1);
    chk("stall_busy_idle", {31'b0, busy}, 32'd0);
    tick;
    user_req = 1'b0; user_we = 1'b0;
    for (int i = 0; i < DEP; i++) exp_mem[i] = 2'b11;
    exp_mem[3] = 2'd1;
    chk("stall_contents", ram_bad(), 32'd0);
    user_req = 1'b1; user_addr = 32'd3;
    tick;
    user_req = 1'b0;
    chk("stall_rb_rvalid", {31'b0, user_rvalid}, 32'd1);
    chk("stall_rb_data", {30'b0, user_dout}, 32'd1);

    // Reserved mode: done next cycle with err, no writes.
    cnt_a = 0;
    start_sweep(2'd3, 2'b01, 32'd0);
    if (mem_we) cnt_a++;
    chk("rsv_done", {31'b0, done}, 32'd1);
    chk("rsv_err", {31'b0, err}, 32'd1);
    chk("rsv_sig_ok", {31'b0, sig_ok}, 32'd0);
    chk("rsv_sig", sig, 32'd0);
    tick;
    if (mem_we) cnt_a++;
    chk("rsv_no_we", cnt_a, 32'd0);
    chk("rsv_idle", {31'b0, busy}, 32'd0);
    chk("rsv_err_hold", {31'b0, err}, 32'd1);

    // Reset asserted at c0+7 of a FILL.
    start_sweep(2'd1, 2'b01, 32'd0);
    repeat (6) tick;
    reset = 1'b0;
    tick;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_err", {31'b0, err}, 32'd0);
    reset = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done) cnt_a++;
    end
    chk("mid_rst_no_done", cnt_a, 32'd0);
    start_sweep(2'd1, 2'b00, 32'd0);
    wait_done(40, lat);
    chk("post_rst_lat", lat, DEP + 1);
    chk("post_rst_sig_ok", {31'b0, sig_ok}, 32'd1);
    for (int i = 0; i < DEP; i++) exp_mem[i] = 2'b00;
    chk("post_rst_contents", ram_bad(), 32'd0);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
